parking_disp_ctrl: RTL

- Tracks parking-lot occupancy from car entry/exit pulses.
- Selects the status message: "OPEn" while spaces remain, "FULL" at capacity.
- Drives a 4-digit, time-multiplexed 7-segment display. Each cycle it emits one 4-bit character code plus active-low anode enables.
- The code feeds the existing character decoder; this block is the producer side of that code interface.

---
 rtl/parking_disp_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/parking_disp_ctrl.sv
// Parking occupancy tracker driving a 4-digit multiplexed "OPEn"/"FULL" display.
// Latency: occupancy/full/reject registered, visible the cycle after the pulse; an/display registered together.
// Backpressure: none; car_in while full is dropped and flagged on reject. Optional blink: PARKING_DISP_BLINK_EN.
module parking_disp_ctrl #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car_in,
  input  logic             car_out,
  output logic [3:0]       display,
  output logic [3:0]       an,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             reject
);

  localparam int              PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(CAPACITY);
  localparam logic [PW-1:0]    PMAX = PW'(SCAN_DIV - 1);

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full_q, full_d;
  logic             reject_q, reject_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       s_q, s_d;
  logic             msg_full_q, msg_full_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       disp_q, disp_d;
  logic             frame_end;
  logic             blank;

  // Character code for digit s of the selected message, leftmost first.
  function automatic logic [3:0] char_code(input logic msg_full, input logic [1:0] s);
    logic [3:0] c;
    c = 4'd3;
    if (msg_full) begin
      case (s)
        2'd0:    c = 4'd2;
        2'd1:    c = 4'd1;
        default: c = 4'd0;
      endcase
    end else begin
      case (s)
        2'd0:    c = 4'd3;
        2'd1:    c = 4'd4;
        2'd2:    c = 4'd5;
        default: c = 4'd6;
      endcase
    end
    return c;
  endfunction

  // Occupancy update; simultaneous in/out cancels, and full is derived from the next count.
  always_comb begin
    occ_d    = occ_q;
    reject_d = 1'b0;
    if (car_in && !car_out) begin
      if (full_q) reject_d = 1'b1;
      else        occ_d    = occ_q + CNT_W'(1);
    end else if (car_out && !car_in && (occ_q != '0)) begin
      occ_d = occ_q - CNT_W'(1);
    end
    full_d = (occ_d == CAP);
  end

  // Prescaler and digit index; message is resampled only when a frame completes.
  always_comb begin
    presc_d    = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
    s_d        = (presc_q == PMAX) ? s_q + 2'd1 : s_q;
    frame_end  = (presc_q == PMAX) && (s_q == 2'd3);
    msg_full_d = frame_end ? full_q : msg_full_q;
  end

`ifdef PARKING_DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;

  // Blink phase: held on while showing OPEn, toggles every BLINK_FRAMES full frames of FULL.
  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (!msg_full_d) begin
      frm_d   = '0;
      phase_d = 1'b1;
    end else if (frame_end && msg_full_q) begin
      if (frm_q == FW'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
    blank = msg_full_d && !phase_d;
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      frm_q   <= frm_d;
      phase_q <= phase_d;
    end
  end
`else
  // The blink period parameter only matters in the blink build.
  logic blink_frames_unused;
  assign blink_frames_unused = (BLINK_FRAMES > 0);
  assign blank = 1'b0;
`endif

  // Next anode/code pair built from the same next index so they never skew.
  always_comb begin
    an_d   = blank ? 4'b1111 : ~(4'b1000 >> s_d);
    disp_d = char_code(msg_full_d, s_d);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      full_q     <= 1'b0;
      reject_q   <= 1'b0;
      presc_q    <= '0;
      s_q        <= 2'd0;
      msg_full_q <= 1'b0;
      an_q       <= 4'b0111;
      disp_q     <= 4'd3;
    end else begin
      occ_q      <= occ_d;
      full_q     <= full_d;
      reject_q   <= reject_d;
      presc_q    <= presc_d;
      s_q        <= s_d;
      msg_full_q <= msg_full_d;
      an_q       <= an_d;
      disp_q     <= disp_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = full_q;
  assign reject    = reject_q;
  assign an        = an_q;
  assign display   = disp_q;

endmodule
